// File: rtl/pulse_event_arbiter_pkg.sv
// pulse_arb_pkg: shared FSM state type and default sizing for the pulse event arbiter
package pulse_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
  localparam int N_REQ_DEF = 4;
  localparam int ID_W_DEF  = 2;
  localparam int GAP_W_DEF = 4;
endpackage

// File: rtl/pulse_event_arbiter_if.sv
// pulse_event_arbiter_if: requester/consumer bundle; master drives requests and config, slave returns strobes and flags
interface pulse_event_arbiter_if import pulse_arb_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = ID_W_DEF,
  parameter int GAP_W = GAP_W_DEF
);
  logic [N_REQ-1:0] req_lvl;
  logic             en;
  logic             ready;
  logic [GAP_W-1:0] gap_cfg;
  logic             ovf_clr;
  logic             pulse_out;
  logic [ID_W-1:0]  pulse_id;
  logic [N_REQ-1:0] pend;
  logic [N_REQ-1:0] ovf;
  modport master (output req_lvl, en, ready, gap_cfg, ovf_clr, input pulse_out, pulse_id, pend, ovf);
  modport slave (input req_lvl, en, ready, gap_cfg, ovf_clr, output pulse_out, pulse_id, pend, ovf);
endinterface

// File: rtl/pulse_event_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search of i_pend starting just above i_last; o_win/o_valid give the winner
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_pend,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_win,
  output logic         o_valid
);
  int w_j;
  // scan from farthest to nearest so the nearest pending slot after i_last wins
  always_comb begin
    o_win = '0;
    o_valid = 1'b0;
    w_j = 0;
    for (int k = N; k >= 1; k--) begin
      w_j = (int'(i_last) + k) % N;
      if (i_pend[w_j]) begin
        o_win = W'(w_j);
        o_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/pulse_event_arbiter.sv
// pulse_event_arbiter: turns requester level rises into round-robin, READY-gated, gap-spaced one-cycle strobes
// ports: clk, rst (async active-high); bus.slave carries req_lvl/en/ready/gap_cfg/ovf_clr in, pulse_out/pulse_id/pend/ovf out
module pulse_event_arbiter import pulse_arb_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = ID_W_DEF,
  parameter int GAP_W = GAP_W_DEF
) (
  input logic clk,
  input logic rst,
  pulse_event_arbiter_if.slave bus
);
  state_t r_state, w_state_n;
  logic [N_REQ-1:0] r_lvl, r_pend, r_ovf, w_rise, w_grant;
  logic [ID_W-1:0] r_last, r_id, w_win;
  logic [GAP_W-1:0] r_gap, w_gap_n;
  logic r_pulse, w_valid, w_go, w_issue;
  rr_pick #(.N(N_REQ), .W(ID_W)) u_pick (
    .i_pend(r_pend),
    .i_last(r_last),
    .o_win(w_win),
    .o_valid(w_valid)
  );
  assign w_rise = bus.req_lvl & ~r_lvl;
  assign w_go = bus.en & bus.ready & w_valid;
  assign w_grant = w_issue ? N_REQ'(1) << w_win : '0;
  // gap_cnt holds its loaded value through the ISSUE cycle so GAP lasts exactly gap_cfg cycles
  always_comb begin
    w_state_n = r_state;
    w_gap_n = r_gap;
    w_issue = 1'b0;
    case (r_state)
      IDLE: w_issue = w_go;
      ISSUE: begin
        w_issue = w_go && r_gap == '0;
        w_state_n = r_gap == '0 ? IDLE : GAP;
      end
      GAP: begin
        w_issue = w_go && r_gap == GAP_W'(1);
        w_state_n = r_gap == GAP_W'(1) ? IDLE : GAP;
        w_gap_n = r_gap - GAP_W'(1);
      end
      default: w_state_n = IDLE;
    endcase
    if (w_issue) begin
      w_state_n = ISSUE;
      w_gap_n = bus.gap_cfg;
    end
  end
  // a rise on the grant edge re-arms the flag; a rise onto an ungranted pending flag is lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_gap <= '0;
      r_lvl <= '0;
      r_pend <= '0;
      r_ovf <= '0;
      r_pulse <= 1'b0;
      r_id <= '0;
      r_last <= ID_W'(N_REQ - 1);
    end else begin
      r_state <= w_state_n;
      r_gap <= w_gap_n;
      r_lvl <= bus.req_lvl;
      r_pend <= (r_pend & ~w_grant) | w_rise;
      r_ovf <= (r_ovf & ~{N_REQ{bus.ovf_clr}}) | (w_rise & r_pend & ~w_grant);
      r_pulse <= w_issue;
      if (w_issue) begin
        r_id <= w_win;
        r_last <= w_win;
      end
    end
  end
  assign bus.pulse_out = r_pulse;
  assign bus.pulse_id = r_id;
  assign bus.pend = r_pend;
  assign bus.ovf = r_ovf;
endmodule

// File: tb/tb_pulse_event_arbiter.sv
// tb_pulse_event_arbiter: vector table, reset corner sequences and randomized run against an event-level model
module tb_pulse_event_arbiter;
  import pulse_arb_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errs = 0;
  int checks = 0;
  pulse_event_arbiter_if #(.N_REQ(4), .ID_W(2), .GAP_W(4)) bus ();
  pulse_event_arbiter #(.N_REQ(4), .ID_W(2), .GAP_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] req;
    logic       en;
    logic       rdy;
    logic [3:0] gap;
    logic       clr;
    logic       p;
    logic [1:0] id;
    logic [3:0] pend;
    logic [3:0] ovf;
  } vec_t;
  vec_t tv[$];
  logic [3:0] m_lvl, m_pend, m_ovf;
  logic [1:0] m_last, m_id;
  logic m_pulse;
  int m_since, m_gap;
  task automatic model_reset();
    m_lvl = '0; m_pend = '0; m_ovf = '0; m_last = 2'd3; m_id = '0; m_pulse = 1'b0;
    m_since = 100; m_gap = 0;
  endtask
  // strobe allowed once more than gap_at_last edges have passed since the previous strobe
  task automatic model_edge();
    logic [3:0] rise, gnt;
    int w;
    rise = bus.req_lvl & ~m_lvl;
    gnt = '0;
    m_pulse = 1'b0;
    if (m_since < 100) m_since++;
    if (bus.en && bus.ready && m_pend != 0 && m_since > m_gap) begin
      w = 0;
      for (int k = 1; k <= 4; k++) begin
        w = (int'(m_last) + k) % 4;
        if (m_pend[w]) break;
      end
      gnt[w] = 1'b1;
      m_last = 2'(w);
      m_id = 2'(w);
      m_gap = int'(bus.gap_cfg);
      m_since = 0;
      m_pulse = 1'b1;
    end
    m_ovf = (bus.ovf_clr ? 4'b0 : m_ovf) | (rise & m_pend & ~gnt);
    m_pend = (m_pend & ~gnt) | rise;
    m_lvl = bus.req_lvl;
  endtask
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  task automatic cyc(input logic [3:0] r, input logic e, input logic rd, input logic [3:0] g, input logic c);
    bus.req_lvl = r; bus.en = e; bus.ready = rd; bus.gap_cfg = g; bus.ovf_clr = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic cmp_model(input string t);
    chk({t, " pulse"}, int'(bus.pulse_out), int'(m_pulse));
    chk({t, " id"}, int'(bus.pulse_id), int'(m_id));
    chk({t, " pend"}, int'(bus.pend), int'(m_pend));
    chk({t, " ovf"}, int'(bus.ovf), int'(m_ovf));
  endtask
  task automatic cmp_zero(input string t);
    chk({t, " pulse"}, int'(bus.pulse_out), 0);
    chk({t, " id"}, int'(bus.pulse_id), 0);
    chk({t, " pend"}, int'(bus.pend), 0);
    chk({t, " ovf"}, int'(bus.ovf), 0);
  endtask
  task automatic add(input logic [3:0] r, input logic e, input logic rd, input logic [3:0] g, input logic c,
                     input logic p, input logic [1:0] id, input logic [3:0] pd, input logic [3:0] ov);
    vec_t v;
    v.req = r; v.en = e; v.rdy = rd; v.gap = g; v.clr = c; v.p = p; v.id = id; v.pend = pd; v.ovf = ov;
    tv.push_back(v);
  endtask
  task automatic rst_mid(input string t);
    #2 rst = 1'b1;
    #1 cmp_zero(t);
    bus.req_lvl = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask
  initial begin
    logic [3:0] r;
    bus.req_lvl = '0; bus.en = 1'b0; bus.ready = 1'b0; bus.gap_cfg = '0; bus.ovf_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 cmp_zero("reset");
    rst = 1'b0;
    // round-robin with gap 2
    add(4'b0000,1,1,2,0, 0,0,4'b0000,4'b0000);
    add(4'b1111,1,1,2,0, 0,0,4'b1111,4'b0000);
    add(4'b1111,1,1,2,0, 1,0,4'b1110,4'b0000);
    add(4'b1111,1,1,2,0, 0,0,4'b1110,4'b0000);
    add(4'b1111,1,1,2,0, 0,0,4'b1110,4'b0000);
    add(4'b1111,1,1,2,0, 1,1,4'b1100,4'b0000);
    add(4'b1111,1,1,2,0, 0,1,4'b1100,4'b0000);
    add(4'b1111,1,1,2,0, 0,1,4'b1100,4'b0000);
    add(4'b1111,1,1,2,0, 1,2,4'b1000,4'b0000);
    add(4'b1111,1,1,2,0, 0,2,4'b1000,4'b0000);
    add(4'b1111,1,1,2,0, 0,2,4'b1000,4'b0000);
    add(4'b1111,1,1,2,0, 1,3,4'b0000,4'b0000);
    add(4'b1111,1,1,2,0, 0,3,4'b0000,4'b0000);
    add(4'b0000,1,1,2,0, 0,3,4'b0000,4'b0000);
    // single event, gap 0
    add(4'b0100,1,1,0,0, 0,3,4'b0100,4'b0000);
    add(4'b0100,1,1,0,0, 1,2,4'b0000,4'b0000);
    add(4'b0100,1,1,0,0, 0,2,4'b0000,4'b0000);
    // back-pressure
    add(4'b0110,1,0,0,0, 0,2,4'b0010,4'b0000);
    for (int i = 0; i < 4; i++) add(4'b0110,1,0,0,0, 0,2,4'b0010,4'b0000);
    add(4'b0110,1,1,0,0, 1,1,4'b0000,4'b0000);
    add(4'b0000,1,1,0,0, 0,1,4'b0000,4'b0000);
    // overflow and clear
    add(4'b1000,0,1,0,0, 0,1,4'b1000,4'b0000);
    add(4'b0000,0,1,0,0, 0,1,4'b1000,4'b0000);
    add(4'b1000,0,1,0,0, 0,1,4'b1000,4'b1000);
    add(4'b1000,0,1,0,1, 0,1,4'b1000,4'b0000);
    add(4'b1000,1,1,0,0, 1,3,4'b0000,4'b0000);
    add(4'b0000,1,1,0,0, 0,3,4'b0000,4'b0000);
    // rise on grant edge
    add(4'b0001,0,1,0,0, 0,3,4'b0001,4'b0000);
    add(4'b0000,0,1,0,0, 0,3,4'b0001,4'b0000);
    add(4'b0001,1,1,1,0, 1,0,4'b0001,4'b0000);
    add(4'b0001,1,1,1,0, 0,0,4'b0001,4'b0000);
    add(4'b0001,1,1,1,0, 1,0,4'b0000,4'b0000);
    add(4'b0000,1,1,1,0, 0,0,4'b0000,4'b0000);
    add(4'b0000,1,1,1,0, 0,0,4'b0000,4'b0000);
    foreach (tv[i]) begin
      cyc(tv[i].req, tv[i].en, tv[i].rdy, tv[i].gap, tv[i].clr);
      chk($sformatf("vec%0d pulse", i), int'(bus.pulse_out), int'(tv[i].p));
      chk($sformatf("vec%0d id", i), int'(bus.pulse_id), int'(tv[i].id));
      chk($sformatf("vec%0d pend", i), int'(bus.pend), int'(tv[i].pend));
      chk($sformatf("vec%0d ovf", i), int'(bus.ovf), int'(tv[i].ovf));
    end
    // reset while a strobe is high: pulse must drop without a clock edge
    cyc(4'b0011,1,1,3,0);
    cyc(4'b0011,1,1,3,0);
    chk("pre-rst strobe", int'(bus.pulse_out), 1);
    rst_mid("rst in issue");
    for (int i = 0; i < 5; i++) begin
      cyc(4'b0000,1,1,0,0);
      chk($sformatf("post-rst1 pulse %0d", i), int'(bus.pulse_out), 0);
      chk($sformatf("post-rst1 pend %0d", i), int'(bus.pend), 0);
    end
    // reset during GAP with two events pending
    cyc(4'b0111,1,1,3,0);
    cyc(4'b0111,1,1,3,0);
    cyc(4'b0111,1,1,3,0);
    cmp_model("gap before rst");
    chk("gap pend count", $countones(bus.pend), 2);
    rst_mid("rst in gap");
    for (int i = 0; i < 5; i++) begin
      cyc(4'b0000,1,1,0,0);
      chk($sformatf("post-rst2 pulse %0d", i), int'(bus.pulse_out), 0);
      chk($sformatf("post-rst2 pend %0d", i), int'(bus.pend), 0);
    end
    cyc(4'b0010,1,1,0,0);
    cyc(4'b0000,1,1,0,0);
    cmp_model("new rise after rst");
    // randomized run against the model
    r = '0;
    for (int i = 0; i < 3000; i++) begin
      r = r ^ (4'($urandom) & 4'($urandom));
      cyc(r, ($urandom % 8) != 0, ($urandom % 4) != 0, 4'($urandom % 4), ($urandom % 16) == 0);
      cmp_model($sformatf("rand%0d", i));
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/pulse_event_arbiter.md
# pulse_event_arbiter

Edge-triggered event scheduler that shares the single-pulse signalling path between several level-type requesters in the system-control clock domain. Each requester's level rise becomes a pending event. Pending events are issued one at a time as one-cycle `PULSE_OUT` strobes tagged with the requester ID. Issue is round-robin fair, gated by a consumer `READY`, with a programmable minimum idle gap between strobes.

## Interface
- `N_REQ`, default 4: number of level requesters; range 2..8.
- `ID_W`, default 2: width of `PULSE_ID`; equals clog2(`N_REQ`).
- `GAP_W`, default 4: width of `GAP_CFG`.
- `CLK` in 1: block clock; all requesters are synchronous to it.
- `RST` in 1: asynchronous, active-high reset.
- `REQ_LVL` in `N_REQ`: level request per source; only a 0->1 transition creates an event.
- `EN` in 1: issue enable; when low, no strobe issues but events are still captured.
- `READY` in 1: consumer can accept a strobe this cycle.
- `GAP_CFG` in `GAP_W`: idle cycles forced after each strobe; sampled at issue.
- `OVF_CLR` in 1: clears all `OVF` bits.
- `PULSE_OUT` out 1: one-cycle strobe, registered.
- `PULSE_ID` out `ID_W`: index of the granted source; valid while `PULSE_OUT`=1; holds last value otherwise.
- `PEND` out `N_REQ`: pending-event flags.
- `OVF` out `N_REQ`: sticky bit per source; set when an event is lost.

## Operation
- **Edge capture:** register `lvl_q` (reset 0).
  - `rise[i]` = `REQ_LVL[i]` & ~`lvl_q[i]`.
  - `rise[i]` sets `PEND[i]` on the same edge.
  - A level already high at reset release counts as one event.
- **FSM states:** IDLE, ISSUE, GAP.
  - **IDLE:** if `EN` & `READY` & |`PEND`, pick a winner. Go to ISSUE with `PULSE_OUT`=1, `PULSE_ID`=winner, clear `PEND[winner]`, load `gap_cnt`=`GAP_CFG`.
  - **ISSUE:** lasts one cycle.
    - If `gap_cnt`=0 and the IDLE issue condition holds, issue again immediately and stay in ISSUE.
    - Else if `gap_cnt`=0, go to IDLE.
    - Else go to GAP.
  - **GAP:** `PULSE_OUT`=0; decrement `gap_cnt` each cycle. From value 1, go to IDLE, or issue directly if the issue condition holds. The gap is exactly `GAP_CFG` idle cycles.
  - `EN` going low does not abort GAP; counting continues.
- **Round-robin:** pointer `last` (reset `N_REQ`-1). Search `PEND` starting at `last`+1 mod `N_REQ`, upward with wrap. On grant, `last` = winner.
- **Simultaneous events:**
  - `rise[i]` on the edge `PEND[i]` is granted: `PEND[i]` stays 1 (new event); no overflow.
  - `rise[i]` while `PEND[i]`=1 and not granted that edge: `OVF[i]` is set; the event is merged.
  - `OVF_CLR` and an overflow set on the same edge: set wins.
- **Reset mid-operation:** all state clears asynchronously; `PULSE_OUT` drops immediately and pending events are discarded.
- **Reset values:** `PULSE_OUT`=0, `PULSE_ID`=0, `PEND`=0, `OVF`=0, FSM=IDLE, `gap_cnt`=0.

## Timing
- **Latency:** `REQ_LVL[i]` first sampled high at edge k sets `PEND[i]` at k. `PULSE_OUT` rises at edge k+1 at the earliest (IDLE, `EN`, `READY`, won arbitration).
- **Throughput:** with `GAP_CFG`=0 and continuous `READY`, one strobe per cycle. Otherwise one strobe per `GAP_CFG`+1 cycles.
- **READY:** sampled at the issue edge only. `READY` low holds issue off; there is no retraction of an issued strobe.
- **GAP_CFG:** a change during GAP takes effect at the next issue.

## Structure
- **Package `pulse_arb_pkg`:** state enum (IDLE, ISSUE, GAP) and default constants for `N_REQ`, `ID_W`, `GAP_W`.
- **Sub-module `rr_pick`:** combinational; inputs `PEND` and `last`; outputs winner index and a `valid` flag. It is reusable by other shared-resource arbiters in the system.
- **Top-level contents:** edge capture, pending/overflow flags, FSM, gap counter.

## Test plan
- **Reset and single event:** hold `RST`=1, then release with `REQ_LVL`=0. Raise bit 2 at edge k with `EN`=`READY`=1 and `GAP_CFG`=0. Expect `PEND[2]`=1 at k, a single strobe at k+1 with ID 2, and `PEND`=0 after.
- **Round-robin with gap:** all four sources rise together, `GAP_CFG`=2. Expect IDs 0,1,2,3, with strobes 3 cycles apart and exactly 2 idle cycles between them.
- **Back-pressure:** `READY`=0 for 5 cycles with source 1 pending. Expect no strobe. Raise `READY` at edge m; expect a strobe at edge m.
- **Overflow:** source 3 rises, falls and rises again while `EN`=0. Expect `PEND[3]`=1 and `OVF[3]`=1. Pulse `OVF_CLR` with no new rise; expect `OVF[3]`=0.
- **Rise on grant edge:** source 0 re-rises on the same edge it is granted. Expect `PEND[0]` to remain 1, `OVF[0]`=0, and a second ID 0 strobe after the gap.
- **Reset mid-operation:** assert `RST` during GAP with 2 events pending. Expect all outputs 0 asynchronously, and no strobes after release until a new rise.
